// File: rtl/data_ram.sv
// ---------------------------------------------------------------------------
// data_ram
// Single-port, word-addressed data memory shared by the load/store path and
// the program loader. Writes are synchronous. Reads pass through one output
// register, so read data appears one cycle after the address.
//
// Ports:
//   i_clk    in   1       clock, rising edge
//   i_rst_n  in   1       asynchronous active-low reset (output register only)
//   i_addr   in   ADDR_W  word address for the read or write
//   i_set    in   1       write enable (1 = write i_data to i_addr)
//   i_data   in   DATA_W  write data
//   o_data   out  DATA_W  registered read data (write-first on a write)
//
// DEPTH must not exceed 2**ADDR_W. Addresses at or above DEPTH read as zero
// and never write the array.
// ---------------------------------------------------------------------------
module data_ram #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 65536
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_set,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_data
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Power-up contents are all zero; the initialiser maps onto the RAM's
  // configuration-time init values.
  logic [DATA_W-1:0] mem [0:DEPTH-1] = '{default: '0};

  logic              in_range;
  logic [IDX_W-1:0]  mem_idx;
  logic              wr_en;
  logic [DATA_W-1:0] data_reg;

  // The range check only exists when the array is smaller than the address
  // space; otherwise every address is valid and the compare would be constant.
  generate
    if (longint'(DEPTH) < (longint'(1) << ADDR_W)) begin : g_partial
      assign in_range = (i_addr < ADDR_W'(DEPTH));
      assign mem_idx  = i_addr[IDX_W-1:0];
    end else begin : g_full
      assign in_range = 1'b1;
      assign mem_idx  = i_addr;
    end
  endgenerate

  // Writes are suppressed while reset is held so the loader cannot corrupt
  // memory during a reset pulse.
  assign wr_en = i_rst_n & i_set & in_range;

  // Array write port: no reset, so the tools keep it in block RAM.
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      mem[mem_idx] <= i_data;
    end
  end

  // Output register. Write-first: on a write the incoming word is returned
  // directly rather than the stale array contents. Out-of-range accesses
  // return zero regardless of i_set.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      data_reg <= '0;
    end else if (!in_range) begin
      data_reg <= '0;
    end else if (i_set) begin
      data_reg <= i_data;
    end else begin
      data_reg <= mem[mem_idx];
    end
  end

  assign o_data = data_reg;

endmodule

// File: tb/tb_data_ram.sv
// ---------------------------------------------------------------------------
// tb_data_ram
// Directed bench for data_ram. A full-size instance (DEPTH = 65536) covers
// power-up, write-first, readback, reset and boundary addresses; a second
// instance with DEPTH = 16 covers out-of-range accesses.
// ---------------------------------------------------------------------------
module tb_data_ram;

  logic        clk;
  logic        rst_n;

  logic [15:0] addr;
  logic        set;
  logic [31:0] wdata;
  logic [31:0] rdata;

  logic [15:0] addr16;
  logic        set16;
  logic [31:0] wdata16;
  logic [31:0] rdata16;

  int n_checks;
  int n_pass;

  data_ram #(.ADDR_W(16), .DATA_W(32), .DEPTH(65536)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_addr  (addr),
    .i_set   (set),
    .i_data  (wdata),
    .o_data  (rdata)
  );

  data_ram #(.ADDR_W(16), .DATA_W(32), .DEPTH(16)) dut16 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_addr  (addr16),
    .i_set   (set16),
    .i_data  (wdata16),
    .o_data  (rdata16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
      $display("check %-22s o_data=%08h expected=%08h ok", tag, obs, exp);
    end else begin
      $error("FAIL %s: o_data=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Drive one access on the full-size instance, let one edge pass, settle.
  task automatic cyc(input logic [15:0] a, input logic s, input logic [31:0] d);
    addr  = a;
    set   = s;
    wdata = d;
    @(posedge clk);
    #1;
  endtask

  // Same for the DEPTH = 16 instance (full-size instance idles).
  task automatic cyc16(input logic [15:0] a, input logic s, input logic [31:0] d);
    addr16  = a;
    set16   = s;
    wdata16 = d;
    set     = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    addr     = '0;
    set      = 1'b0;
    wdata    = '0;
    addr16   = '0;
    set16    = 1'b0;
    wdata16  = '0;

    #1;
    check("reset_state", rdata, 32'h0000_0000);
    check("reset_state_d16", rdata16, 32'h0000_0000);
    #1 rst_n = 1'b1;

    // Power-up reads: all zero
    cyc(16'd0, 1'b0, '0); check("pwrup_rd_0", rdata, 32'h0);
    cyc(16'd1, 1'b0, '0); check("pwrup_rd_1", rdata, 32'h0);
    cyc(16'd2, 1'b0, '0); check("pwrup_rd_2", rdata, 32'h0);
    cyc(16'd3, 1'b0, '0); check("pwrup_rd_3", rdata, 32'h0);

    // Write-first
    cyc(16'd0, 1'b1, 32'hAAAA_AAAA); check("wr_first_0", rdata, 32'hAAAA_AAAA);
    cyc(16'd2, 1'b1, 32'hAAAA_AAAA); check("wr_first_2", rdata, 32'hAAAA_AAAA);

    // Readback
    cyc(16'd0, 1'b0, '0); check("rdback_0", rdata, 32'hAAAA_AAAA);
    cyc(16'd1, 1'b0, '0); check("rdback_1", rdata, 32'h0000_0000);
    cyc(16'd2, 1'b0, '0); check("rdback_2", rdata, 32'hAAAA_AAAA);
    cyc(16'd3, 1'b0, '0); check("rdback_3", rdata, 32'h0000_0000);

    // Inputs changing between edges must not disturb o_data
    cyc(16'd0, 1'b0, '0);
    addr = 16'd1; set = 1'b1; wdata = 32'h5555_5555;
    #3;
    check("hold_between_edges", rdata, 32'hAAAA_AAAA);

    // Reset mid-operation: o_data is AAAAAAAA from address 0
    rst_n = 1'b0;
    #1;
    check("async_reset_clear", rdata, 32'h0);
    addr = 16'd0; set = 1'b1; wdata = 32'h5555_5555;
    @(posedge clk); #1;
    check("reset_hold_zero", rdata, 32'h0);
    #2 rst_n = 1'b1;
    cyc(16'd0, 1'b0, '0); check("post_reset_rd_0", rdata, 32'hAAAA_AAAA);
    cyc(16'd1, 1'b0, '0); check("post_reset_rd_1", rdata, 32'h0000_0000);

    // Overwrite existing word, then read it back
    cyc(16'd2, 1'b1, 32'h0F0F_0F0F); check("overwrite_2", rdata, 32'h0F0F_0F0F);
    cyc(16'd2, 1'b0, '0);            check("overwrite_rd_2", rdata, 32'h0F0F_0F0F);

    // Top address, back to back, no wrap
    cyc(16'hFFFF, 1'b1, 32'h1234_5678); check("wr_top", rdata, 32'h1234_5678);
    cyc(16'hFFFF, 1'b0, '0);            check("rd_top", rdata, 32'h1234_5678);
    cyc(16'h0000, 1'b0, '0);            check("no_wrap_0", rdata, 32'hAAAA_AAAA);
    cyc(16'hFFFE, 1'b0, '0);            check("rd_top_m1", rdata, 32'h0000_0000);

    // DEPTH = 16 instance
    cyc16(16'd0,  1'b1, 32'h1111_1111); check("d16_wr_0", rdata16, 32'h1111_1111);
    cyc16(16'd15, 1'b1, 32'h2222_2222); check("d16_wr_15", rdata16, 32'h2222_2222);
    cyc16(16'd16, 1'b1, 32'hDEAD_BEEF); check("d16_wr_oor", rdata16, 32'h0);
    cyc16(16'd0,  1'b0, '0);            check("d16_rd_0", rdata16, 32'h1111_1111);
    cyc16(16'd16, 1'b0, '0);            check("d16_rd_oor", rdata16, 32'h0);
    cyc16(16'd15, 1'b0, '0);            check("d16_rd_15", rdata16, 32'h2222_2222);
    cyc16(16'hFFFF, 1'b0, '0);          check("d16_rd_ffff", rdata16, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
